fpmul_initiator: RTL and testbench
==================================

FPMUL_INITIATOR -- requirements
Module: fpmul_initiator

Interface
REQ-001 Parameter DEPTH, default 4: operand FIFO entries; power of two, minimum 2.
REQ-002 Parameter TIMEOUT, default 64: cycles allowed from operand acceptance to result arrival (used only with REQ-030).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ld_valid  in  1  load port: operand pair offered.
REQ-006 ld_ready  out  1  load port: FIFO not full.
REQ-007 ld_a, ld_b  in  32 each  IEEE-754 single-precision operands to load.
REQ-008 op_valid  out  1  multiplier side: operand pair presented.
REQ-009 op_ready  in  1  multiplier side: multiplier accepts operands.
REQ-010 op_a, op_b  out  32 each  operands presented to multiplier.
REQ-011 res_valid  in  1  multiplier result present.
REQ-012 res_ready  out  1  initiator accepts result.
REQ-013 res_data  in  32  multiplier product Z.
REQ-014 out_valid  out  1  completed triple available.
REQ-015 out_ready  in  1  downstream accepts triple.
REQ-016 out_a, out_b, out_z  out  32 each  operands and product of completed transaction.
REQ-017 txn_cnt  out  16  count of completed (delivered) transactions.
REQ-018 err_timeout  out  1  sticky timeout flag (with macro, REQ-030; otherwise tied 0).

Function
REQ-019 Any transfer on any port occurs on a rising edge where its valid and ready are both 1.
REQ-020 FIFO: push on load transfer, pop on operand issue; ld_ready = not full; simultaneous push and pop when full is not possible (ld_ready=0); simultaneous push and pop when non-empty leaves occupancy unchanged; pointers wrap modulo DEPTH.
REQ-021 FSM states: IDLE, ISSUE, AWAIT, DELIVER; at most one transaction outstanding at the multiplier.
REQ-022 IDLE: op_valid=0, res_ready=0, out_valid=0; FIFO non-empty -> ISSUE next cycle with head loaded into op_a/op_b.
REQ-023 ISSUE: op_valid=1; op_a/op_b stable until transfer; on op_ready=1 -> pop FIFO, copy op_a/op_b into held operand registers, op_valid=0 next cycle, -> AWAIT.
REQ-024 AWAIT: res_ready=1; res_valid=1 -> capture res_data into out_z, held operands into out_a/out_b, -> DELIVER; res_valid while not in AWAIT is ignored (res_ready=0).
REQ-025 DELIVER: out_valid=1, out_a/out_b/out_z stable; on out_ready=1 -> txn_cnt increments (wraps 0xFFFF->0x0000), out_valid=0 next cycle, -> ISSUE if FIFO non-empty after this cycle, else IDLE.
REQ-026 Latency: empty FIFO, load at cycle 0 -> op_valid=1 at cycle 2; out_valid rises the cycle after result capture.
REQ-027 Loading continues in all states while FIFO not full.

Reset
REQ-028 rst=0 at any time, including mid-transaction, immediately clears: FSM to IDLE, FIFO empty, op_valid=0, res_ready=0, out_valid=0, ld_ready=0 while asserted then 1 from first edge after release, txn_cnt=0, err_timeout=0, all data outputs 0; in-flight transaction discarded.

Configuration
REQ-029 Macro FPMUL_INIT_TIMEOUT_EN selects watchdog logic.
REQ-030 Defined: counter runs in AWAIT; reaching TIMEOUT cycles without res_valid sets err_timeout (sticky until reset) and forces AWAIT -> IDLE (or ISSUE if FIFO non-empty), transaction dropped, txn_cnt unchanged. Undefined: no counter, AWAIT waits indefinitely, err_timeout constant 0.

Verification
REQ-031 Load 0x3FC00000, 0x40000000 (1.5, 2.0); model returns 0x40400000 -> out_a=0x3FC00000, out_b=0x40000000, out_z=0x40400000, txn_cnt=1.
REQ-032 Load DEPTH+1 pairs with op_ready=0 -> ld_ready=0 after DEPTH loads; release op_ready -> all DEPTH+1 pairs delivered in load order.
REQ-033 Hold op_ready=0 for 10 cycles in ISSUE -> op_valid stays 1, op_a/op_b unchanged each cycle; out_ready=0 for 5 cycles -> triple held stable.
REQ-034 Assert rst=0 in AWAIT with 3 pairs queued -> all outputs at reset values same cycle; FIFO empty, txn_cnt=0 after release.
REQ-035 With FPMUL_INIT_TIMEOUT_EN, TIMEOUT=64, model never returns result -> err_timeout=1 at 64th AWAIT cycle, next queued pair issued; without macro, op_valid stays 0 indefinitely.

Source files
------------

// File: rtl/fpmul_initiator.sv
// Operand-queueing initiator for a single-precision FP multiplier: buffers operand pairs,
// issues one at a time, collects the product and delivers {a, b, z}. Watchdog: FPMUL_INIT_TIMEOUT_EN.
`timescale 1ns/1ps
module fpmul_initiator #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_a,
   input  logic [31:0] ld_b,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic [31:0] res_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [31:0] out_z,
   output logic [15:0] txn_cnt,
   output logic        err_timeout,
   output logic [1:0]  dbg_state
);

   // Every port transfers on a rising edge where its valid and ready are both 1;
   // a valid, once raised, holds its payload stable until that transfer.

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
      $error("fpmul_initiator: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_AWAIT   = 2'd2,
      S_DELIVER = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [AW:0]   w_count_nxt;
   logic          r_ld_en;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_nonempty_nxt;
   logic [63:0]   w_head;
   logic          w_load_op;
   logic          w_capture;
   logic          w_deliver;

   logic [31:0]   r_op_a;
   logic [31:0]   r_op_b;
   logic [31:0]   r_hold_a;
   logic [31:0]   r_hold_b;
   logic [31:0]   r_out_a;
   logic [31:0]   r_out_b;
   logic [31:0]   r_out_z;
   logic [15:0]   r_txn_cnt;

   // ld_ready is held low until the first edge after reset release
   assign w_full         = (r_count == FULL_CNT);
   assign ld_ready       = r_ld_en & ~w_full;
   assign w_push         = ld_valid & ld_ready;
   assign w_pop          = (r_state == S_ISSUE) & op_ready;
   assign w_count_nxt    = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
   assign w_nonempty_nxt = (w_count_nxt != '0);

   // Leaving AWAIT/DELIVER onto an empty FIFO that is being loaded this cycle: bypass
   assign w_head = (r_count != '0) ? r_mem[r_rd_ptr] : {ld_a, ld_b};

`ifdef FPMUL_INIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_err_timeout;
   logic          w_timeout;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_load_op   = 1'b0;
      w_capture   = 1'b0;
      w_deliver   = 1'b0;
`ifdef FPMUL_INIT_TIMEOUT_EN
      w_timeout   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_state_nxt = S_ISSUE;
               w_load_op   = 1'b1;
            end
         end
         S_ISSUE: begin
            if (op_ready) w_state_nxt = S_AWAIT;
         end
         S_AWAIT: begin
            if (res_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DELIVER;
            end
`ifdef FPMUL_INIT_TIMEOUT_EN
            else if (r_to_cnt == TO_LAST) begin
               w_timeout   = 1'b1;
               w_load_op   = w_nonempty_nxt;
               w_state_nxt = w_nonempty_nxt ? S_ISSUE : S_IDLE;
            end
`endif
         end
         S_DELIVER: begin
            if (out_ready) begin
               w_deliver   = 1'b1;
               w_load_op   = w_nonempty_nxt;
               w_state_nxt = w_nonempty_nxt ? S_ISSUE : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {ld_a, ld_b};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_ld_en   <= 1'b0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_hold_a  <= '0;
         r_hold_b  <= '0;
         r_out_a   <= '0;
         r_out_b   <= '0;
         r_out_z   <= '0;
         r_txn_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_ld_en <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_hold_a <= r_op_a;
            r_hold_b <= r_op_b;
         end
         if (w_load_op) begin
            r_op_a <= w_head[63:32];
            r_op_b <= w_head[31:0];
         end
         if (w_capture) begin
            r_out_a <= r_hold_a;
            r_out_b <= r_hold_b;
            r_out_z <= res_data;
         end
         if (w_deliver) r_txn_cnt <= r_txn_cnt + 16'd1;
      end
   end

`ifdef FPMUL_INIT_TIMEOUT_EN
   // Counts cycles spent in AWAIT; restarts on every entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_to_cnt      <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         if (r_state == S_AWAIT && !w_timeout && !res_valid) r_to_cnt <= r_to_cnt + 1'b1;
         else r_to_cnt <= '0;
         if (w_timeout) r_err_timeout <= 1'b1;
      end
   end

   assign err_timeout = r_err_timeout;
`else
   assign err_timeout = 1'b0;
`endif

   assign op_valid  = (r_state == S_ISSUE);
   assign res_ready = (r_state == S_AWAIT);
   assign out_valid = (r_state == S_DELIVER);
   assign op_a      = r_op_a;
   assign op_b      = r_op_b;
   assign out_a     = r_out_a;
   assign out_b     = r_out_b;
   assign out_z     = r_out_z;
   assign txn_cnt   = r_txn_cnt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_fpmul_initiator.sv
// Bench for fpmul_initiator: directed operand/product vectors, a replaying multiplier model,
// and a scoreboard monitor that checks every delivered triple in load order.
`timescale 1ns/1ps
module tb_fpmul_initiator;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int NVEC    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_a;
   logic [31:0] ld_b;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [31:0] out_z;
   logic [15:0] txn_cnt;
   logic        err_timeout;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;
   int n_deliv  = 0;

   logic [95:0] exp_q[$];
   logic [31:0] mul_z_q[$];
   logic        mul_hold = 1'b0;
   logic        mul_drop = 1'b0;

   logic [31:0] vec_a [NVEC];
   logic [31:0] vec_b [NVEC];
   logic [31:0] vec_z [NVEC];

   fpmul_initiator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_a        (ld_a),
      .ld_b        (ld_b),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_z       (out_z),
      .txn_cnt     (txn_cnt),
      .err_timeout (err_timeout),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic load(input int idx);
      bit done = 1'b0;
      ld_valid = 1'b1;
      ld_a     = vec_a[idx];
      ld_b     = vec_b[idx];
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = ld_ready;
         @(posedge clk);
         #1;
      end
      ld_valid = 1'b0;
      if (done) begin
         exp_q.push_back({vec_a[idx], vec_b[idx], vec_z[idx]});
         mul_z_q.push_back(vec_z[idx]);
      end else begin
         check("load_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic wait_state(input logic [1:0] st, input int max_cyc, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         if (dbg_state == st) ok = 1'b1;
      end
      check(name, {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && out_valid !== 1'b1) ok = 1'b1;
      end
      check(name, {31'd0, ok}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
      check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
      check("rst_op_valid", {31'd0, op_valid}, 32'd0);
      exp_q.delete();
      mul_z_q.delete();
      n_deliv = 0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ld_ready_after_release", {31'd0, ld_ready}, 32'd1);
   endtask

   // ---------------- multiplier model ----------------
   initial begin
      logic [31:0] z;
      res_valid = 1'b0;
      res_data  = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && op_valid === 1'b1 && op_ready === 1'b1) begin
            if (mul_z_q.size() == 0) begin
               check("mul_unexpected_issue", 32'd0, 32'd1);
               z = '0;
            end else begin
               z = mul_z_q.pop_front();
            end
            @(posedge clk);
            while (mul_hold) @(posedge clk);
            #1;
            if (!mul_drop) begin
               res_valid = 1'b1;
               res_data  = z;
               for (int i = 0; i < 200; i++) begin
                  @(negedge clk);
                  if (res_ready || !rst) break;
               end
               @(posedge clk);
               #1;
               res_valid = 1'b0;
               res_data  = '0;
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [95:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("out_a", out_a, e[95:64]);
               check("out_b", out_b, e[63:32]);
               check("out_z", out_z, e[31:0]);
               check("txn_cnt_at_out", {16'd0, txn_cnt}, n_deliv & 32'hFFFF);
               n_deliv++;
            end
         end
      end
   end

   // ---------------- global watchdog ----------------
   initial begin
      #500000;
      failures++;
      $display("FAIL global_timeout checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      // 1.5*2.0, 2.0*2.0, 1.0*1.0, -1.0*2.0, 0.5*4.0, 3.0*0.5, 5.0*2.0, -3.0*-3.0
      vec_a[0] = 32'h3FC00000; vec_b[0] = 32'h40000000; vec_z[0] = 32'h40400000;
      vec_a[1] = 32'h40000000; vec_b[1] = 32'h40000000; vec_z[1] = 32'h40800000;
      vec_a[2] = 32'h3F800000; vec_b[2] = 32'h3F800000; vec_z[2] = 32'h3F800000;
      vec_a[3] = 32'hBF800000; vec_b[3] = 32'h40000000; vec_z[3] = 32'hC0000000;
      vec_a[4] = 32'h3F000000; vec_b[4] = 32'h40800000; vec_z[4] = 32'h40000000;
      vec_a[5] = 32'h40400000; vec_b[5] = 32'h3F000000; vec_z[5] = 32'h3FC00000;
      vec_a[6] = 32'h40A00000; vec_b[6] = 32'h40000000; vec_z[6] = 32'h41200000;
      vec_a[7] = 32'hC0400000; vec_b[7] = 32'hC0400000; vec_z[7] = 32'h41100000;

      rst       = 1'b0;
      ld_valid  = 1'b0;
      ld_a      = '0;
      ld_b      = '0;
      op_ready  = 1'b0;
      out_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("init_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("init_op_valid", {31'd0, op_valid}, 32'd0);
      check("init_res_ready", {31'd0, res_ready}, 32'd0);
      check("init_out_valid", {31'd0, out_valid}, 32'd0);
      check("init_txn_cnt", {16'd0, txn_cnt}, 32'd0);
      check("init_err_timeout", {31'd0, err_timeout}, 32'd0);
      check("init_out_z", out_z, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("ld_ready_before_first_edge", {31'd0, ld_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("ld_ready_after_release", {31'd0, ld_ready}, 32'd1);

      // single transaction, 1.5 * 2.0, with issue latency
      load(0);
      @(negedge clk);
      check("lat_cycle1_op_valid", {31'd0, op_valid}, 32'd0);
      @(negedge clk);
      check("lat_cycle2_op_valid", {31'd0, op_valid}, 32'd1);
      check("lat_cycle2_op_a", op_a, 32'h3FC00000);
      check("lat_cycle2_op_b", op_b, 32'h40000000);
      @(posedge clk);
      #1;
      op_ready = 1'b1;
      wait_drain("drain_single");
      check("txn_cnt_after_single", {16'd0, txn_cnt}, 32'd1);

      // fill FIFO with multiplier stalled, then overflow pair
      @(posedge clk);
      #1;
      op_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) load(i);
      @(negedge clk);
      check("fifo_full_ld_ready", {31'd0, ld_ready}, 32'd0);
      fork
         load(DEPTH + 1);
         begin
            repeat (3) begin
               @(negedge clk);
               check("fifo_full_hold", {31'd0, ld_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            op_ready = 1'b1;
         end
      join
      wait_drain("drain_fill");
      check("txn_cnt_after_fill", {16'd0, txn_cnt}, 32'd6);

      // operand stability while op_ready low, triple stability while out_ready low
      @(posedge clk);
      #1;
      op_ready = 1'b0;
      load(6);
      wait_state(2'd1, 10, "reach_issue");
      repeat (10) begin
         @(negedge clk);
         check("stall_op_valid", {31'd0, op_valid}, 32'd1);
         check("stall_op_a", op_a, 32'h40A00000);
         check("stall_op_b", op_b, 32'h40000000);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      op_ready  = 1'b1;
      wait_state(2'd3, 20, "reach_deliver");
      repeat (5) begin
         @(negedge clk);
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_out_a", out_a, 32'h40A00000);
         check("hold_out_b", out_b, 32'h40000000);
         check("hold_out_z", out_z, 32'h41200000);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain("drain_stall");
      check("txn_cnt_after_stall", {16'd0, txn_cnt}, 32'd7);

      // reset while awaiting a result with three pairs queued
      mul_hold = 1'b1;
      mul_drop = 1'b1;
      for (int i = 0; i < 4; i++) load(i);
      wait_state(2'd2, 10, "reach_await");
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_op_valid", {31'd0, op_valid}, 32'd0);
      check("mid_rst_res_ready", {31'd0, res_ready}, 32'd0);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("mid_rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
      check("mid_rst_op_a", op_a, 32'd0);
      check("mid_rst_op_b", op_b, 32'd0);
      check("mid_rst_out_a", out_a, 32'd0);
      check("mid_rst_out_z", out_z, 32'd0);
      check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
      exp_q.delete();
      mul_z_q.delete();
      n_deliv = 0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_ld_ready_release", {31'd0, ld_ready}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("fifo_empty_after_rst", {31'd0, op_valid}, 32'd0);
      end
      check("txn_cnt_after_rst", {16'd0, txn_cnt}, 32'd0);
      @(posedge clk);
      #1;
      mul_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mul_drop = 1'b0;

      // multiplier never answers
      mul_hold = 1'b1;
      mul_drop = 1'b1;
      load(1);
      load(2);
      wait_state(2'd2, 10, "reach_await_nores");
`ifdef FPMUL_INIT_TIMEOUT_EN
      begin
         bit seen = 1'b0;
         for (int i = 0; i < TIMEOUT + 20 && !seen; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) seen = 1'b1;
         end
         check("timeout_flag", {31'd0, seen}, 32'd1);
         wait_state(2'd1, 5, "timeout_next_issue");
         check("timeout_next_op_a", op_a, vec_a[2]);
      end
`else
      begin
         int bad = 0;
         repeat (TIMEOUT + 40) begin
            @(negedge clk);
            if (op_valid !== 1'b0 || err_timeout !== 1'b0 || res_ready !== 1'b1) bad++;
         end
         check("no_timeout_wait", bad, 32'd0);
      end
`endif
      @(posedge clk);
      #1;
      do_reset();
      mul_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mul_drop = 1'b0;

      // all vectors with random backpressure on both sides
      fork
         for (int i = 0; i < NVEC; i++) load(i);
         begin
            repeat (60) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
               op_ready  = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
            op_ready  = 1'b1;
         end
      join
      wait_drain("drain_random");
      check("txn_cnt_final", {16'd0, txn_cnt}, NVEC);
      check("err_timeout_final", {31'd0, err_timeout}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
